// File: rtl/uart_ns_rx.sv
// UART receiver: 2-flop synchronised rx pin, mid-bit sampling with a programmable
// baud divisor (no oversampling), 8N1/8N2 framing, one-entry valid/ready output.
module uart_ns_rx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  baud_div_i,
   input  logic              two_stop_bits,
   input  logic              rx_pin_i,
   input  logic              rx_ready_i,
   output logic              rx_valid_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              frame_err_o,
   output logic              overrun_o
);

   localparam int unsigned BIDX_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   logic                r_sync1;
   logic                r_rx_s;
   logic                r_rx_d;
   logic [DIV_W-1:0]    r_div_q;
   logic [DIV_W-1:0]    r_cnt;
   logic [BIDX_W-1:0]   r_bit_idx;
   logic [1:0]          r_stop_left;
   logic [DATA_W-1:0]   r_shift;
   logic                r_valid;
   logic [DATA_W-1:0]   r_data;
   logic                r_ferr;
   logic                r_ovr;

   state_t              w_state_nxt;
   logic [DIV_W-1:0]    w_div_nxt;
   logic [DIV_W-1:0]    w_cnt_nxt;
   logic [BIDX_W-1:0]   w_bit_nxt;
   logic [1:0]          w_stop_nxt;
   logic [DATA_W-1:0]   w_shift_nxt;
   logic                w_fall;
   logic                w_done;
   logic                w_ferr;
   logic                w_pop;
   logic                w_load;
   logic                w_valid_nxt;
   logic [DATA_W-1:0]   w_data_nxt;
   logic                w_ovr;

   assign w_fall = r_rx_d & ~r_rx_s;

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div_q;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit_idx;
      w_stop_nxt  = r_stop_left;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fall) begin
               w_div_nxt   = baud_div_i;
               w_cnt_nxt   = (baud_div_i >> 1) - DIV_W'(1);
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == '0) begin
               // a start bit that is high again at mid-bit was only a glitch
               if (!r_rx_s) begin
                  w_cnt_nxt   = r_div_q - DIV_W'(1);
                  w_bit_nxt   = '0;
                  w_state_nxt = S_DATA;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_W'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == '0) begin
               w_shift_nxt = {r_rx_s, r_shift[DATA_W-1:1]};
               w_cnt_nxt   = r_div_q - DIV_W'(1);
               w_bit_nxt   = r_bit_idx + BIDX_W'(1);
               if (r_bit_idx == BIDX_W'(DATA_W - 1)) begin
                  w_stop_nxt  = two_stop_bits ? 2'd2 : 2'd1;
                  w_state_nxt = S_STOP;
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_W'(1);
            end
         end
         S_STOP: begin
            if (r_cnt == '0) begin
               if (!r_rx_s) begin
                  w_ferr      = 1'b1;
                  w_state_nxt = S_IDLE;
               end else if (r_stop_left > 2'd1) begin
                  w_stop_nxt = r_stop_left - 2'd1;
                  w_cnt_nxt  = r_div_q - DIV_W'(1);
               end else begin
                  // leave at mid-stop so a start edge right after it is not missed
                  w_done      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - DIV_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_pop       = r_valid & rx_ready_i;
      w_load      = w_done & (~r_valid | w_pop);
      w_ovr       = w_done & r_valid & ~w_pop;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      if (w_load) begin
         w_valid_nxt = 1'b1;
         w_data_nxt  = r_shift;
      end else if (w_pop) begin
         w_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sync1     <= 1'b1;
         r_rx_s      <= 1'b1;
         r_rx_d      <= 1'b1;
         r_div_q     <= '0;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_stop_left <= '0;
         r_shift     <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_ferr      <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_sync1     <= rx_pin_i;
         r_rx_s      <= r_sync1;
         r_rx_d      <= r_rx_s;
         r_div_q     <= w_div_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_idx   <= w_bit_nxt;
         r_stop_left <= w_stop_nxt;
         r_shift     <= w_shift_nxt;
         r_valid     <= w_valid_nxt;
         r_data      <= w_data_nxt;
         r_ferr      <= w_ferr;
         r_ovr       <= w_ovr;
      end
   end

   assign rx_valid_o  = r_valid;
   assign rx_data_o   = r_data;
   assign frame_err_o = r_ferr;
   assign overrun_o   = r_ovr;

endmodule

// File: tb/tb_uart_ns_rx.sv
// Bench for uart_ns_rx: directed scenarios plus random frames checked against
// a frame-level reference (good frame -> byte, bad stop -> one error pulse).
module tb_uart_ns_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] baud_div_i;
   logic       two_stop_bits;
   logic       rx_pin_i;
   logic       rx_ready_i;
   logic       rx_valid_o;
   logic [7:0] rx_data_o;
   logic       frame_err_o;
   logic       overrun_o;

   uart_ns_rx #(.DATA_W(8), .DIV_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .baud_div_i    (baud_div_i),
      .two_stop_bits (two_stop_bits),
      .rx_pin_i      (rx_pin_i),
      .rx_ready_i    (rx_ready_i),
      .rx_valid_o    (rx_valid_o),
      .rx_data_o     (rx_data_o),
      .frame_err_o   (frame_err_o),
      .overrun_o     (overrun_o)
   );

   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_ferr  = 0;
   int         n_ovr   = 0;
   int         cyc     = 0;
   int         first_valid = -1;
   logic [10:0] rst_snap;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      if (i < got_q.size()) return {24'h0, got_q[i]};
      return 32'hDEAD_BEEF;
   endfunction

   // one clock: record a pop that this edge performs, then sample pulses after it
   task automatic tick();
      if (rx_valid_o && rx_ready_i) got_q.push_back(rx_data_o);
      @(posedge clk);
      #1;
      cyc++;
      if (frame_err_o) n_ferr++;
      if (overrun_o) n_ovr++;
      if (rx_valid_o && first_valid < 0) first_valid = cyc;
   endtask

   task automatic idle(input int n);
      rx_pin_i = 1'b1;
      repeat (n) tick();
   endtask

   // pulse_at: frame tick at which rx_ready_i is high for one cycle (-1 = untouched)
   // rst_at  : frame tick at which rst_n is low for one cycle (-1 = none)
   task automatic send_frame(input logic [7:0] b, input int div, input int nstop,
                             input bit bad_stop, input int pulse_at, input int rst_at);
      int   bi;
      logic v;
      for (int t = 0; t < (9 + nstop) * div; t++) begin
         bi = t / div;
         if (bi == 0)      v = 1'b0;
         else if (bi <= 8) v = b[bi-1];
         else              v = !(bad_stop && bi == 9);
         rx_pin_i = v;
         if (pulse_at >= 0) rx_ready_i = (t == pulse_at);
         rst_n = (t != rst_at);
         tick();
         if (t == rst_at) rst_snap = {rx_valid_o, frame_err_o, overrun_o, rx_data_o};
      end
      rst_n = 1'b1;
      if (pulse_at >= 0) rx_ready_i = 1'b0;
   endtask

   initial begin
      int          div;
      int          exp_ferr;
      bit          two;
      bit          bad;
      logic [7:0]  b;

      rst_n = 1'b0; rx_pin_i = 1'b1; rx_ready_i = 1'b0;
      baud_div_i = 8'd16; two_stop_bits = 1'b0;
      repeat (3) tick();
      check("rst_valid", {31'h0, rx_valid_o}, 32'h0);
      check("rst_data", {24'h0, rx_data_o}, 32'h0);
      check("rst_ferr", {31'h0, frame_err_o}, 32'h0);
      check("rst_ovr", {31'h0, overrun_o}, 32'h0);
      rst_n = 1'b1;
      idle(5);

      // 0xA5, div 16, one stop, consumer not ready
      n_ferr = 0; n_ovr = 0; cyc = 0; first_valid = -1;
      send_frame(8'hA5, 16, 1, 1'b0, -1, -1);
      idle(4);
      check("a5_latency_window", {31'h0, (first_valid >= 152 && first_valid <= 158)}, 32'h1);
      check("a5_valid", {31'h0, rx_valid_o}, 32'h1);
      check("a5_data", {24'h0, rx_data_o}, 32'hA5);
      check("a5_no_err", n_ferr + n_ovr, 0);
      rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0; tick();
      check("a5_pop_clears", {31'h0, rx_valid_o}, 32'h0);

      // start glitch
      rx_pin_i = 1'b0;
      repeat (3) tick();
      idle(40);
      check("glitch_no_valid", {31'h0, rx_valid_o}, 32'h0);
      check("glitch_no_ferr", n_ferr, 0);

      // framing error, long break, then a good frame
      n_ferr = 0;
      send_frame(8'h5A, 16, 1, 1'b1, -1, -1);
      rx_pin_i = 1'b0;
      repeat (40) tick();
      idle(5);
      check("ferr_one_pulse", n_ferr, 1);
      check("ferr_no_valid", {31'h0, rx_valid_o}, 32'h0);
      got_q.delete();
      rx_ready_i = 1'b1;
      send_frame(8'h11, 16, 1, 1'b0, -1, -1);
      idle(20);
      rx_ready_i = 1'b0;
      check("ferr_next_count", got_q.size(), 1);
      check("ferr_next_data", got_at(0), 32'h11);

      // overrun: second byte dropped
      n_ovr = 0;
      send_frame(8'h12, 16, 1, 1'b0, -1, -1);
      idle(4);
      send_frame(8'h34, 16, 1, 1'b0, -1, -1);
      idle(4);
      check("ovr_pulse", n_ovr, 1);
      check("ovr_data_kept", {24'h0, rx_data_o}, 32'h12);
      check("ovr_valid", {31'h0, rx_valid_o}, 32'h1);
      rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0; tick();
      check("ovr_pop", {31'h0, rx_valid_o}, 32'h0);

      // pop in the exact completion cycle: edge 2 + div/2 + 9*div = 154
      send_frame(8'h12, 16, 1, 1'b0, -1, -1);
      idle(4);
      n_ovr = 0; got_q.delete();
      send_frame(8'h34, 16, 1, 1'b0, 154, -1);
      idle(4);
      check("pop_load_no_ovr", n_ovr, 0);
      check("pop_load_data", {24'h0, rx_data_o}, 32'h34);
      check("pop_load_valid", {31'h0, rx_valid_o}, 32'h1);
      check("pop_load_popped", got_at(0), 32'h12);
      rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0; tick();

      // reset during bit 4 with an unread byte held
      send_frame(8'h77, 16, 1, 1'b0, -1, -1);
      idle(4);
      n_ferr = 0; n_ovr = 0;
      send_frame(8'hF0, 16, 1, 1'b0, -1, 5 * 16 + 8);
      check("midrst_outputs", {21'h0, rst_snap}, 32'h0);
      idle(20);
      check("midrst_no_byte", {31'h0, rx_valid_o}, 32'h0);
      check("midrst_no_err", n_ferr + n_ovr, 0);
      got_q.delete();
      rx_ready_i = 1'b1;
      send_frame(8'hC3, 16, 1, 1'b0, -1, -1);
      idle(20);
      check("midrst_next_count", got_q.size(), 1);
      check("midrst_next_data", got_at(0), 32'hC3);

      // random frames, divisors and stop modes, consumer always ready
      got_q.delete(); exp_q.delete();
      n_ferr = 0; n_ovr = 0; exp_ferr = 0;
      rx_ready_i = 1'b1;
      for (int k = 0; k < 24; k++) begin
         div = $urandom_range(4, 40);
         two = 1'($urandom_range(0, 1));
         b   = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         baud_div_i    = 8'(div);
         two_stop_bits = two;
         send_frame(b, div, two ? 2 : 1, bad, -1, -1);
         if (bad) exp_ferr++;
         else     exp_q.push_back(b);
         idle($urandom_range(bad ? 2 : 0, div));
      end
      idle(100);
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("rand_byte_%0d", i), got_at(i), {24'h0, exp_q[i]});
      check("rand_ferr", n_ferr, exp_ferr);
      check("rand_no_ovr", n_ovr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_ns_rx.md
Name: uart_ns_rx

Overview:
- UART receive stage; the downstream counterpart of the UART transmitter on the serial line.
- Samples the asynchronous rx pin at mid-bit, using the same baud divisor semantics as the TX side: baud_div_i clock cycles per bit, no oversampling.
- Frame format: 8N1 or 8N2, LSB first.
- Delivers each received byte through a one-entry valid/ready holding register to the UART register interface, and flags framing and overrun errors.

Parameters:
- DATA_W, 8, data bits per frame.
- DIV_W, 8, width of the baud divisor and the sample counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- baud_div_i  in  DIV_W  clock cycles per bit. Legal range 4..2^DIV_W-1.
- two_stop_bits  in  1  1 = check two stop bits, 0 = check one.
- rx_pin_i  in  1  asynchronous serial input; idle level is high.
- rx_ready_i  in  1  consumer accepts the held byte.
- rx_valid_o  out  1  holding register contains an unread byte.
- rx_data_o  out  DATA_W  received byte.
- frame_err_o  out  1  one-cycle pulse: a stop bit was sampled low.
- overrun_o  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; both synchronizer flops = 1; all counters = 0.
  - rx_valid_o = 0, rx_data_o = 0, frame_err_o = 0, overrun_o = 0.
  - Reset mid-frame abandons the frame. After reset, a new start is recognised only on a fresh high-to-low edge.
- Synchronizer:
  - rx_pin_i passes through 2 flops to give rx_s; a third flop gives rx_d.
  - falling edge = rx_d & ~rx_s.
- Divisor latch: div_q captures baud_div_i on start detection. Changes to baud_div_i mid-frame have no effect on that frame.
- State machine (IDLE, START, DATA, STOP):
  - IDLE: on a falling edge, latch div_q, load cnt = (baud_div_i>>1)-1, go to START. No edge means no action; a line held low does not retrigger.
  - START: cnt decrements each cycle.
    - At cnt==0, if rx_s==0: cnt = div_q-1, bit_idx = 0, go to DATA.
    - At cnt==0, if rx_s==1: treat as a glitch and return to IDLE with no output.
  - DATA: cnt decrements each cycle. At cnt==0:
    - shift rx_s in at the MSB with a right shift (LSB first on the wire);
    - reload cnt = div_q-1;
    - increment bit_idx.
    - After the DATA_W-th sample: stop_left = two_stop_bits ? 2 : 1, go to STOP.
  - STOP: cnt decrements each cycle. At cnt==0 sample rx_s:
    - If 0: frame_err_o pulses for the next cycle, the byte is discarded, go to IDLE.
    - If 1 and stop_left>1: decrement stop_left and reload cnt = div_q-1.
    - If 1 and stop_left==1: the byte is complete; go to IDLE in the same cycle, so a start edge immediately after a half-stop bit is caught.
- Holding register:
  - Byte completion and pop are evaluated in the same cycle. Pop = rx_valid_o & rx_ready_i.
  - Complete, and (!rx_valid_o or pop): rx_data_o <= byte, rx_valid_o <= 1 on the next edge. A simultaneous pop and load gives no overrun.
  - Complete, rx_valid_o=1, no pop: overrun_o pulses 1 cycle; the new byte is dropped and rx_data_o is unchanged.
  - Pop without completion: rx_valid_o <= 0; rx_data_o keeps its last value.
- Latency:
  - Falling edge on the pin to the mid-stop sample: 2 synchronizer cycles + 1 edge-detect cycle, plus (div>>1) + (DATA_W+1)*div cycles.
  - rx_valid_o rises 1 cycle after the final stop sample.
- Widths: counters are DIV_W bits and never wrap, because div_q >= 4 guarantees cnt loads ≥ 1. Operation with baud_div_i < 4 is undefined.

Test Plan:
- baud_div_i=16, one stop bit, line driven with 0xA5 (start, 1,0,1,0,0,1,0,1, stop), rx_ready_i=0 → rx_valid_o=1 and rx_data_o=0xA5 about 152 cycles after the falling edge; no error pulses. Raising rx_ready_i for 1 cycle clears rx_valid_o.
- Loopback: uart_ns_tx → uart_ns_rx, baud_div=10, two_stop_bits=1, bytes 0x00, 0xFF, 0x3C sent back-to-back, rx_ready_i=1 → three valid bytes in order, no frame_err_o or overrun_o.
- Start glitch: baud_div=16, line low for 3 cycles then high → state returns to IDLE; rx_valid_o stays 0.
- Framing error: 0x5A with a stop bit of 0 → frame_err_o high for exactly 1 cycle; rx_valid_o stays 0. The line is then held low for 40 cycles and released, and a following 0x11 frame is received correctly.
- Overrun: 0x12 then 0x34 with rx_ready_i=0 → overrun_o pulses once at the end of 0x34; rx_data_o stays 0x12. Variant: pulse rx_ready_i in the exact completion cycle of 0x34 → no overrun, and rx_data_o=0x34.
- Reset mid-frame: assert rst_n=0 for 1 cycle during bit 4 → all outputs 0. The rest of the aborted frame produces no byte; the next frame, 0xC3, is received correctly.
